// File: rtl/rx_frame_arbiter.sv
// Two-source frame arbiter in front of a single byte-stream receiver: whole-frame
// grants with round-robin on contention, enforced inter-frame gap and length truncation.
module rx_frame_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1518,
  parameter int LEN_W      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  output logic        gnt0,
  input  logic [7:0]  rxd0,
  input  logic        rx_dv0,
  input  logic        req1,
  output logic        gnt1,
  input  logic [7:0]  rxd1,
  input  logic        rx_dv1,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1,
  output logic        trunc
);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, GAP} state_t;

  state_t           r_state, w_state;
  logic             r_sel, w_sel;
  logic             r_ptr, w_ptr;
  logic [LEN_W-1:0] r_len, w_len;
  logic             r_trunc_seen, w_trunc_seen;
  logic [GAP_W-1:0] r_gap, w_gap;
  logic [7:0]       r_txd, w_txd;
  logic             r_tx_en, w_tx_en;
  logic             r_gnt0, w_gnt0;
  logic             r_gnt1, w_gnt1;
  logic [15:0]      r_cnt0, w_cnt0;
  logic [15:0]      r_cnt1, w_cnt1;
  logic             r_trunc, w_trunc;

  logic       w_req;
  logic       w_dv;
  logic [7:0] w_rxd;
  logic       w_winner;

  // Only the owning source's inputs are ever looked at
  assign w_req    = r_sel ? req1   : req0;
  assign w_dv     = r_sel ? rx_dv1 : rx_dv0;
  assign w_rxd    = r_sel ? rxd1   : rxd0;
  assign w_winner = (req0 && req1) ? r_ptr : req1;

  always_comb begin
    w_state      = r_state;
    w_sel        = r_sel;
    w_ptr        = r_ptr;
    w_len        = r_len;
    w_trunc_seen = r_trunc_seen;
    w_gap        = r_gap;
    w_txd        = r_txd;
    w_tx_en      = 1'b0;
    w_gnt0       = r_gnt0;
    w_gnt1       = r_gnt1;
    w_cnt0       = r_cnt0;
    w_cnt1       = r_cnt1;
    w_trunc      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_sel        = w_winner;
          w_gnt0       = ~w_winner;
          w_gnt1       = w_winner;
          w_len        = '0;
          w_trunc_seen = 1'b0;
          w_state      = GRANT;
        end else begin
          w_state = IDLE;
        end
      end
      GRANT, BUSY: begin
        if (w_dv) begin
          w_state = BUSY;
          if (r_len < LEN_MAX) begin
            w_txd   = w_rxd;
            w_tx_en = 1'b1;
            w_len   = r_len + 1'b1;
          end else if (!r_trunc_seen) begin
            w_trunc      = 1'b1;
            w_trunc_seen = 1'b1;
          end else begin
            w_trunc = 1'b0;
          end
        end else if (r_state == GRANT) begin
          // Source gave up before sending anything: release without counting
          if (!w_req) begin
            w_gnt0  = 1'b0;
            w_gnt1  = 1'b0;
            w_ptr   = ~r_sel;
            w_state = IDLE;
          end else begin
            w_state = GRANT;
          end
        end else begin
          w_gnt0 = 1'b0;
          w_gnt1 = 1'b0;
          w_ptr  = ~r_sel;
          if (r_sel) begin
            w_cnt1 = r_cnt1 + 16'h0001;
          end else begin
            w_cnt0 = r_cnt0 + 16'h0001;
          end
          if (IFG_CYCLES == 0) begin
            w_state = IDLE;
          end else begin
            w_gap   = GAP_LOAD;
            w_state = GAP;
          end
        end
      end
      GAP: begin
        if (r_gap == '0) begin
          w_state = IDLE;
        end else begin
          w_gap = r_gap - 1'b1;
        end
      end
      default: begin
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel        <= 1'b0;
      r_ptr        <= 1'b0;
      r_len        <= '0;
      r_trunc_seen <= 1'b0;
      r_gap        <= '0;
      r_txd        <= 8'h00;
      r_tx_en      <= 1'b0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_cnt0       <= 16'h0000;
      r_cnt1       <= 16'h0000;
      r_trunc      <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_sel        <= w_sel;
      r_ptr        <= w_ptr;
      r_len        <= w_len;
      r_trunc_seen <= w_trunc_seen;
      r_gap        <= w_gap;
      r_txd        <= w_txd;
      r_tx_en      <= w_tx_en;
      r_gnt0       <= w_gnt0;
      r_gnt1       <= w_gnt1;
      r_cnt0       <= w_cnt0;
      r_cnt1       <= w_cnt1;
      r_trunc      <= w_trunc;
    end
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign txd        = r_txd;
  assign tx_en      = r_tx_en;
  assign frame_cnt0 = r_cnt0;
  assign frame_cnt1 = r_cnt1;
  assign trunc      = r_trunc;
endmodule

// File: tb/tb_rx_frame_arbiter.sv
// Directed self-checking bench: instance A (IFG 12, MAX_LEN 4) for arbitration and
// truncation, instance B (IFG 0) for back-to-back one-byte frames.
module tb_rx_frame_arbiter;
  localparam int IFG_A = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, rx_dv0, req1, rx_dv1;
  logic [7:0]  rxd0, rxd1;
  logic        gnt0, gnt1, tx_en, trunc;
  logic [7:0]  txd;
  logic [15:0] frame_cnt0, frame_cnt1;

  logic        b_req0, b_dv0;
  logic [7:0]  b_rxd0;
  logic        b_gnt0, b_gnt1, b_tx_en, b_trunc;
  logic [7:0]  b_txd;
  logic [15:0] b_cnt0, b_cnt1;

  int checks = 0;
  int errors = 0;
  int idle_run = 0;
  int burst_gap = 0;

  rx_frame_arbiter #(.IFG_CYCLES(IFG_A), .MAX_LEN(4), .LEN_W(11)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .gnt0(gnt0), .rxd0(rxd0), .rx_dv0(rx_dv0),
    .req1(req1), .gnt1(gnt1), .rxd1(rxd1), .rx_dv1(rx_dv1),
    .txd(txd), .tx_en(tx_en), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1),
    .trunc(trunc)
  );

  rx_frame_arbiter #(.IFG_CYCLES(0), .MAX_LEN(1518), .LEN_W(11)) dut_b (
    .clk(clk), .rst(rst),
    .req0(b_req0), .gnt0(b_gnt0), .rxd0(b_rxd0), .rx_dv0(b_dv0),
    .req1(1'b0), .gnt1(b_gnt1), .rxd1(8'h00), .rx_dv1(1'b0),
    .txd(b_txd), .tx_en(b_tx_en), .frame_cnt0(b_cnt0), .frame_cnt1(b_cnt1),
    .trunc(b_trunc)
  );

  // Advance one cycle and track the idle run on instance A's tx_en
  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_en) begin
      if (idle_run != 0) burst_gap = idle_run;
      idle_run = 0;
    end else begin
      idle_run++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; rx_dv0 = 1'b0; rx_dv1 = 1'b0;
    rxd0 = 8'h00; rxd1 = 8'h00;
    b_req0 = 1'b0; b_dv0 = 1'b0; b_rxd0 = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_src(input int src, input logic dv, input logic [7:0] d);
    if (src == 0) begin rx_dv0 = dv; rxd0 = d; end
    else begin rx_dv1 = dv; rxd1 = d; end
  endtask

  // Wait for a grant to src, send n bytes, check forwarding, truncation and frame end
  task automatic play_frame(input int src, input int n, input logic [7:0] base,
                            input int nfwd, input int min_idle, input bit drop_req);
    bit got;
    logic own, other;
    logic [7:0] exp_d;
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (gnt0 || gnt1) begin got = 1'b1; break; end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_wait src%0d: no grant within 40 cycles, required a grant", src);
      return;
    end
    own   = (src == 1) ? gnt1 : gnt0;
    other = (src == 1) ? gnt0 : gnt1;
    checks++;
    if ({own, other} !== 2'b10) begin
      errors++;
      $display("FAIL grant_owner: gnt0=%b gnt1=%b, required grant to src%0d only", gnt0, gnt1, src);
    end
    for (int i = 0; i < n; i++) begin
      drive_src(src, 1'b1, base + 8'(i));
      drive_src(1 - src, 1'b1, 8'hEE);
      tick();
      exp_d = base + 8'(i);
      checks++;
      if (gnt0 && gnt1) begin
        errors++;
        $display("FAIL grant_overlap: gnt0=1 gnt1=1, required at most one");
      end
      if (i < nfwd) begin
        checks++;
        if (tx_en !== 1'b1 || txd !== exp_d) begin
          errors++;
          $display("FAIL fwd_byte %0d: tx_en=%b txd=%h, required tx_en=1 txd=%h", i, tx_en, txd, exp_d);
        end
        if (i == 0) begin
          checks++;
          if (burst_gap < min_idle) begin
            errors++;
            $display("FAIL ifg: idle cycles=%0d, required >=%0d", burst_gap, min_idle);
          end
        end
      end else begin
        checks++;
        if (tx_en !== 1'b0) begin
          errors++;
          $display("FAIL dropped_byte %0d: tx_en=%b, required 0", i, tx_en);
        end
      end
      checks++;
      if (trunc !== (i == nfwd)) begin
        errors++;
        $display("FAIL trunc byte %0d: trunc=%b, required %b", i, trunc, (i == nfwd));
      end
    end
    drive_src(src, 1'b0, 8'h00);
    drive_src(1 - src, 1'b0, 8'h00);
    if (drop_req) begin
      if (src == 0) req0 = 1'b0; else req1 = 1'b0;
    end
    tick();
    checks++;
    if (tx_en !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || trunc !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: tx_en=%b gnt0=%b gnt1=%b trunc=%b, required all 0",
               tx_en, gnt0, gnt1, trunc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; rx_dv0 = 1'b1; rx_dv1 = 1'b1;
    rxd0 = 8'h5A; rxd1 = 8'hA5;
    b_req0 = 1'b1; b_dv0 = 1'b1; b_rxd0 = 8'h33;
    tick();
    tick();
    checks++;
    if ({gnt0, gnt1, tx_en, trunc} !== 4'b0000 || txd !== 8'h00 ||
        frame_cnt0 !== 16'h0000 || frame_cnt1 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_a: gnt=%b%b tx_en=%b trunc=%b txd=%h cnt0=%h cnt1=%h, required all 0",
               gnt0, gnt1, tx_en, trunc, txd, frame_cnt0, frame_cnt1);
    end
    checks++;
    if ({b_gnt0, b_gnt1, b_tx_en, b_trunc} !== 4'b0000 || b_cnt0 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_b: gnt=%b%b tx_en=%b trunc=%b cnt0=%h, required all 0",
               b_gnt0, b_gnt1, b_tx_en, b_trunc, b_cnt0);
    end
    do_reset();
    tick();
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: gnt0=%b gnt1=%b, required 0 0", gnt0, gnt1);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    req0 = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || tx_en !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: gnt0=%b gnt1=%b tx_en=%b, required 1 0 0", gnt0, gnt1, tx_en);
    end
    tick();
    play_frame(0, 4, 8'h11, 4, 0, 1'b1);
    checks++;
    if (frame_cnt0 !== 16'd1 || frame_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL single_count: cnt0=%0d cnt1=%0d, required 1 0", frame_cnt0, frame_cnt1);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    play_frame(0, 3, 8'hA0, 3, 0, 1'b0);
    play_frame(1, 3, 8'hB0, 3, IFG_A, 1'b0);
    play_frame(0, 3, 8'hA8, 3, IFG_A, 1'b1);
    play_frame(1, 3, 8'hB8, 3, IFG_A, 1'b1);
    checks++;
    if (frame_cnt0 !== 16'd2 || frame_cnt1 !== 16'd2) begin
      errors++;
      $display("FAIL contention_count: cnt0=%0d cnt1=%0d, required 2 2", frame_cnt0, frame_cnt1);
    end
  endtask

  task automatic test_truncation();
    int wait_cyc;
    do_reset();
    req1 = 1'b1;
    play_frame(1, 7, 8'hC0, 4, 0, 1'b1);
    checks++;
    if (frame_cnt1 !== 16'd1 || frame_cnt0 !== 16'd0) begin
      errors++;
      $display("FAIL trunc_count: cnt1=%0d cnt0=%0d, required 1 0", frame_cnt1, frame_cnt0);
    end
    req0 = 1'b1;
    wait_cyc = 0;
    for (int t = 0; t < 40; t++) begin
      if (gnt0) break;
      tick();
      wait_cyc++;
    end
    checks++;
    if (wait_cyc != IFG_A + 1) begin
      errors++;
      $display("FAIL trunc_next_grant: waited %0d cycles, required %0d", wait_cyc, IFG_A + 1);
    end
  endtask

  task automatic test_abandoned_grant();
    do_reset();
    req1 = 1'b1;
    rx_dv0 = 1'b1;
    rxd0 = 8'h77;
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || tx_en !== 1'b0) begin
        errors++;
        $display("FAIL abandon_hold c%0d: gnt1=%b gnt0=%b tx_en=%b, required 1 0 0",
                 c, gnt1, gnt0, tx_en);
      end
    end
    req1 = 1'b0;
    rx_dv0 = 1'b0;
    req0 = 1'b1;
    tick();
    checks++;
    if (gnt1 !== 1'b0 || gnt0 !== 1'b0 || tx_en !== 1'b0 || frame_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL abandon_drop: gnt1=%b gnt0=%b tx_en=%b cnt1=%0d, required 0 0 0 0",
               gnt1, gnt0, tx_en, frame_cnt1);
    end
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL abandon_next: gnt0=%b gnt1=%b, required 1 0", gnt0, gnt1);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit got;
    do_reset();
    req0 = 1'b1;
    play_frame(0, 1, 8'h5A, 1, 0, 1'b0);
    checks++;
    if (frame_cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL premid_count: cnt0=%0d, required 1", frame_cnt0);
    end
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (gnt0) begin got = 1'b1; break; end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL mid_grant_wait: gnt0=%b, required 1 within 40 cycles", gnt0);
    end
    for (int i = 0; i < 2; i++) begin
      rx_dv0 = 1'b1;
      rxd0 = 8'h51 + 8'(i);
      tick();
    end
    rxd0 = 8'h53;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx_en !== 1'b0 || gnt0 !== 1'b0 || frame_cnt0 !== 16'd0 || frame_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: tx_en=%b gnt0=%b cnt0=%0d cnt1=%0d, required 0 0 0 0",
               tx_en, gnt0, frame_cnt0, frame_cnt1);
    end
    do_reset();
    req0 = 1'b1;
    play_frame(0, 6, 8'h61, 4, 0, 1'b1);
    checks++;
    if (frame_cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_count: cnt0=%0d, required 1", frame_cnt0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    b_req0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (b_gnt0 !== 1'b1 || b_tx_en !== 1'b0) begin
        errors++;
        $display("FAIL b2b_grant %0d: gnt0=%b tx_en=%b, required 1 0", k, b_gnt0, b_tx_en);
      end
      b_dv0 = 1'b1;
      b_rxd0 = 8'h30 + 8'(k);
      tick();
      checks++;
      if (b_tx_en !== 1'b1 || b_txd !== 8'h30 + 8'(k)) begin
        errors++;
        $display("FAIL b2b_byte %0d: tx_en=%b txd=%h, required 1 %h", k, b_tx_en, b_txd, 8'h30 + 8'(k));
      end
      b_dv0 = 1'b0;
      tick();
      checks++;
      if (b_gnt0 !== 1'b0 || b_tx_en !== 1'b0 || b_cnt0 !== 16'(k + 1)) begin
        errors++;
        $display("FAIL b2b_end %0d: gnt0=%b tx_en=%b cnt0=%0d, required 0 0 %0d",
                 k, b_gnt0, b_tx_en, b_cnt0, k + 1);
      end
    end
    b_req0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_contention();
    test_truncation();
    test_abandoned_grant();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
